cache2vias_ctrl: RTL

Controller for the 2-way set-associative cache data array: accepts CPU read/write requests, holds tag/valid/LRU state, and drives the array's `address_cache`, `hit`, `writecache` and `dado` inputs. On a miss it fetches the word from RAM through a request/acknowledge handshake. Write policy is write-through with write-allocate. It sits between the CPU and the data array and owns the RAM port; the RAM's read data goes directly to the array's `dado_ram` input.

---
 rtl/cache2vias_if.sv | 37 +++
 rtl/cache2vias_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cache2vias_if.sv
// Bus bundle for the 2-way cache controller: CPU request port, data-array control and RAM port.
// The controller takes the slave view; the CPU/array/RAM environment takes the master view.
interface cache2vias_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 3
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ready;
   logic [DATA_W-1:0] cpu_rdata;

   logic [DATA_W-1:0] data_out;
   logic [2:0]        address_cache;
   logic              hit;
   logic              writecache;
   logic [DATA_W-1:0] dado;

   logic              ram_req;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_ack;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, data_out, ram_ack,
      output cpu_ready, cpu_rdata, address_cache, hit, writecache, dado,
             ram_req, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, data_out, ram_ack,
      input  cpu_ready, cpu_rdata, address_cache, hit, writecache, dado,
             ram_req, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/cache2vias_ctrl.sv
// 2-way set-associative cache controller: tag/valid/LRU bookkeeping, data-array strobes and a
// write-through, write-allocate RAM port with req/ack handshake.
module cache2vias_ctrl #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 3
) (
   input logic         clock,
   input logic         reset_n,
   cache2vias_if.slave bus
);
   localparam int unsigned TagW = ADDR_W - 2;

   typedef enum logic [2:0] {StIdle, StLookup, StFill, StWriteRam, StDone} state_e;

   state_e                    state_q, state_d;
   logic                      we_q, we_d;
   logic [ADDR_W-1:0]         addr_q, addr_d;
   logic [DATA_W-1:0]         wdata_q, wdata_d;
   logic [DATA_W-1:0]         rdata_q, rdata_d;
   logic                      victim_q, victim_d;
   logic [3:0][1:0]           valid_q, valid_d;
   logic [3:0][1:0][TagW-1:0] tag_q, tag_d;
   logic [3:0]                lru_q, lru_d;

   logic [1:0]      idx;
   logic [TagW-1:0] tag;
   logic            hit0, hit1, hit_way;

   assign idx     = addr_q[1:0];
   assign tag     = addr_q[ADDR_W-1:2];
   assign hit0    = valid_q[idx][0] && (tag_q[idx][0] == tag);
   assign hit1    = valid_q[idx][1] && (tag_q[idx][1] == tag);
   assign hit_way = ~hit0;

   assign bus.cpu_rdata = rdata_q;

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      victim_d = victim_q;
      valid_d  = valid_q;
      tag_d    = tag_q;
      lru_d    = lru_q;

      // Idle array controls: hit must stay high or the array would capture RAM data.
      bus.cpu_ready     = 1'b0;
      bus.hit           = 1'b1;
      bus.writecache    = 1'b0;
      bus.address_cache = 3'b000;
      bus.dado          = '0;
      bus.ram_req       = 1'b0;
      bus.ram_we        = 1'b0;
      bus.ram_addr      = '0;
      bus.ram_wdata     = '0;

      unique case (state_q)
         StIdle: begin
            if (bus.cpu_req) begin
               we_d    = bus.cpu_we;
               addr_d  = bus.cpu_addr;
               wdata_d = bus.cpu_wdata;
               state_d = StLookup;
            end
         end
         StLookup: begin
            if (hit0 || hit1) begin
               bus.address_cache = {hit_way, idx};
               lru_d[idx]        = ~hit_way;
               if (we_q) begin
                  bus.writecache = 1'b1;
                  bus.dado       = wdata_q;
                  state_d        = StWriteRam;
               end else begin
                  rdata_d = bus.data_out;
                  state_d = StDone;
               end
            end else begin
               if (!valid_q[idx][0]) begin
                  victim_d = 1'b0;
               end else if (!valid_q[idx][1]) begin
                  victim_d = 1'b1;
               end else begin
                  victim_d = lru_q[idx];
               end
               state_d = StFill;
            end
         end
         StFill: begin
            bus.ram_req  = 1'b1;
            bus.ram_addr = addr_q;
            if (bus.ram_ack) begin
               // Array latches dado_ram straight from RAM on this edge.
               bus.hit                 = 1'b0;
               bus.address_cache       = {victim_q, idx};
               valid_d[idx][victim_q]  = 1'b1;
               tag_d[idx][victim_q]    = tag;
               lru_d[idx]              = ~victim_q;
               state_d                 = StLookup;
            end
         end
         StWriteRam: begin
            bus.ram_req   = 1'b1;
            bus.ram_we    = 1'b1;
            bus.ram_addr  = addr_q;
            bus.ram_wdata = wdata_q;
            if (bus.ram_ack) begin
               state_d = StDone;
            end
         end
         StDone: begin
            bus.cpu_ready = 1'b1;
            state_d       = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         victim_q <= 1'b0;
         valid_q  <= '0;
         tag_q    <= '0;
         lru_q    <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         victim_q <= victim_d;
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         lru_q    <= lru_d;
      end
   end
endmodule
